// File: rtl/uart_transmit_fifo.sv
// UART transmitter with a built-in transmit FIFO. Frame format is set by parameters:
// 5..9 data bits, none/even/odd parity, and 1 or 2 stop bits.
//
// state  | meaning
// IDLE   | line high; pops the FIFO head as soon as a word is queued
// START  | start bit (line low)
// DATA   | data bits, LSB first
// PARITY | parity bit (only when PARITY_MODE != 0)
// STOP   | stop bit(s); the last cycle may pop directly into the next START
module uart_transmit_fifo #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600,
    parameter int DATA_BITS        = 8,
    parameter int PARITY_MODE      = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic                          busy_out,
    output logic                          tx_wire_out
);

    localparam int BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int BAUD_W          = $clog2(BAUD_BIT_PERIOD);
    localparam int PTR_W           = $clog2(FIFO_DEPTH);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_BIT_PERIOD - 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [0:0]        STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       count;

    logic [2:0]           state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [3:0]           bit_idx;
    logic [0:0]           stop_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;

    logic                 push;
    logic                 pop;
    logic                 bit_done;
    logic                 frame_end;
    logic [DATA_BITS-1:0] head;
    logic                 head_parity;

    // Depth is a power of two, so the count MSB alone flags "full".
    assign ready_out      = !count[PTR_W] && !rst_in;
    assign push           = valid_in && ready_out;
    assign bit_done       = (baud_cnt == BAUD_LAST);
    assign frame_end      = (state == S_STOP) && bit_done && (stop_idx == STOP_LAST);
    assign pop            = (count != '0) && !rst_in && ((state == S_IDLE) || frame_end);
    assign head           = mem[rd_ptr];
    assign head_parity    = (^head) ^ (PARITY_MODE == 2);
    assign fifo_count_out = count;
    assign busy_out       = (state != S_IDLE);

    always_comb begin
        tx_wire_out = 1'b1;
        case (state)
            S_START:  tx_wire_out = 1'b0;
            S_DATA:   tx_wire_out = shift_reg[0];
            S_PARITY: tx_wire_out = parity_bit;
            default:  tx_wire_out = 1'b1;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            stop_idx   <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            if (state == S_IDLE || bit_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift_reg  <= head;
                        parity_bit <= head_parity;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == DATA_LAST) begin
                            stop_idx <= '0;
                            state    <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_done) begin
                        stop_idx <= '0;
                        state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        if (stop_idx == STOP_LAST) begin
                            // Back-to-back frames: the next START begins with no idle gap.
                            if (pop) begin
                                shift_reg  <= head;
                                parity_bit <= head_parity;
                                state      <= S_START;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
